mod_addsub: RTL and testbench
=============================

Name: mod_addsub

Overview:
- Modular add/subtract sequencer that sits directly upstream of the multi-precision adder (mpadder) and drives its start/subtract/in_a/in_b/result/done port set.
- Computes (A + B) mod M or (A − B) mod M for 1024-bit operands using two sequential adder passes:
  - pass 1: raw add or subtract;
  - pass 2: conditional correction by the modulus.
- Used as the reduction building block of the Montgomery datapath.

Parameters:
- N, 1024, operand and modulus width in bits.
- AW, 1027, adder input width; operands are zero-extended from N to AW.

Ports:
- clk  in  1  rising-edge clock.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- subtract  in  1  0 = modular add, 1 = modular subtract; sampled with start.
- in_a  in  N  operand A; requirement A < M.
- in_b  in  N  operand B; requirement B < M.
- in_m  in  N  modulus M; requirement M > 0.
- result  out  N  modular result; valid when done is high, held until the next accepted start.
- done  out  1  one-cycle pulse when result is valid.
- busy  out  1  high from the cycle after an accepted start until done.
- adder_start  out  1  one-cycle pulse to the adder.
- adder_subtract  out  1  adder operation select.
- adder_in_a  out  AW  adder operand a.
- adder_in_b  out  AW  adder operand b.
- adder_result  in  AW+1  adder output. For subtraction, bit AW is the borrow flag (1 = negative). Low AW bits hold the two's-complement result modulo 2^AW.
- adder_done  in  1  adder completion pulse.

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE; result=0, done=0, busy=0, adder_start=0, adder_subtract=0, adder_in_a=0, adder_in_b=0; internal registers cleared.
  - Reset mid-operation abandons the operation: no done pulse, and a late adder_done is ignored once in IDLE.
- On accepted start: in_a, in_b, in_m and subtract are captured into internal registers. Inputs may change afterwards.
- FSM states: IDLE, P1_ISSUE, P1_WAIT, P2_ISSUE, P2_WAIT, FINISH.
- IDLE: if start, capture operands -> P1_ISSUE. If start=0, remain.
- P1_ISSUE:
  - adder_start=1 for this cycle only.
  - adder_subtract = op.
  - adder_in_a = {0,A}; adder_in_b = {0,B}.
  - -> P1_WAIT.
- P1_WAIT: hold adder_in_*/adder_subtract stable. On adder_done, latch R1 = adder_result[AW-1:0] and flag F = adder_result[AW] -> P2_ISSUE.
- P2_ISSUE:
  - add: adder_subtract=1, adder_in_a=R1, adder_in_b={0,M}.
  - sub: adder_subtract=0, adder_in_a=R1, adder_in_b={0,M}.
  - adder_start pulse -> P2_WAIT.
- P2_WAIT: hold inputs. On adder_done, latch R2 = adder_result[AW-1:0] and flag G = adder_result[AW] -> FINISH.
- Result selection in FINISH:
  - add: result = G ? R1[N-1:0] : R2[N-1:0]. G=1 means A+B < M.
  - sub: result = F ? R2[N-1:0] : R1[N-1:0]. F=1 means A < B, so the corrected value is taken. Wrap modulo 2^AW in R1+M is intended; only the low N bits are kept.
- FINISH: result registered, done=1 for exactly this cycle, busy=0 in this cycle -> IDLE.
- Pass 2 always executes, even when not needed, so latency is fixed.
- Latency: with an adder that asserts done L cycles after its start, done asserts 2L+4 cycles after the start cycle. For L=2, that is 8 cycles.
- start while busy or in FINISH is ignored and not queued. start in the cycle after FINISH is accepted.
- adder_start never asserts outside the P*_ISSUE states. adder_done outside P*_WAIT is ignored.
- Operands violating A,B < M produce an unspecified result but must not hang the FSM.

Test Plan:
- Modular add, wrap: M=13, A=7, B=9, subtract=0 -> result=3; done pulse 8 cycles after start with the 2-cycle adder model; busy high in between.
- Modular add, no wrap: M=13, A=3, B=4 -> result=7. Modular add, boundary: A=B=12 -> result=11.
- Modular subtract, both flag cases:
  - M=13, A=3, B=9, subtract=1 -> result=7 (borrow path).
  - M=13, A=9, B=3 -> result=6.
  - A=B=5 -> result=0.
- Full-width: M=2^1024−1, A=M−1, B=M−1, add -> result=M−2. Same M, A=0, B=1, subtract -> result=M−1.
- Handshake and control:
  - start pulsed again during P1_WAIT with different operands -> ignored; first result delivered; exactly one done.
  - back-to-back starts, with the second start issued the cycle after done -> both results correct.
- Reset in P2_WAIT -> all outputs 0 immediately, no done. The following adder_done is ignored. A new operation then completes correctly.

Source files
------------

// File: rtl/mod_addsub.sv
// rtl/mod_addsub.sv - modular add/subtract sequencer driving a multi-precision adder
module mod_addsub #(
    parameter int N  = 1024,
    parameter int AW = 1027
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic          subtract,
    input  logic [N-1:0]  in_a,
    input  logic [N-1:0]  in_b,
    input  logic [N-1:0]  in_m,
    output logic [N-1:0]  result,
    output logic          done,
    output logic          busy,
    output logic          adder_start,
    output logic          adder_subtract,
    output logic [AW-1:0] adder_in_a,
    output logic [AW-1:0] adder_in_b,
    input  logic [AW:0]   adder_result,
    input  logic          adder_done
);

    localparam int EXT = AW - N;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        P1_ISSUE = 3'd1,
        P1_WAIT  = 3'd2,
        P2_ISSUE = 3'd3,
        P2_WAIT  = 3'd4,
        FINISH   = 3'd5
    } state_t;

    state_t         state;
    logic           op_q;   // 1 = modular subtract
    logic [N-1:0]   m_q;    // captured modulus
    logic [N-1:0]   r1_q;   // pass-1 raw result (low N bits)
    logic           f_q;    // pass-1 borrow: A < B
    logic [N-1:0]   r2_q;   // pass-2 corrected result (low N bits)
    logic           g_q;    // pass-2 borrow: A + B < M
    logic [N-1:0]   sel_result;

    // Pick raw or corrected value: add keeps R1 when R1-M went negative,
    // subtract takes R1+M only when A-B went negative.
    always_comb begin
        sel_result = '0;
        if (op_q) begin
            sel_result = f_q ? r2_q : r1_q;
        end else begin
            sel_result = g_q ? r1_q : r2_q;
        end
    end

    // Sequencer: two fixed adder passes, all outputs registered.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            op_q           <= 1'b0;
            m_q            <= '0;
            r1_q           <= '0;
            f_q            <= 1'b0;
            r2_q           <= '0;
            g_q            <= 1'b0;
            result         <= '0;
            done           <= 1'b0;
            busy           <= 1'b0;
            adder_start    <= 1'b0;
            adder_subtract <= 1'b0;
            adder_in_a     <= '0;
            adder_in_b     <= '0;
        end else begin
            done        <= 1'b0;
            adder_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        op_q           <= subtract;
                        m_q            <= in_m;
                        adder_subtract <= subtract;
                        adder_in_a     <= {{EXT{1'b0}}, in_a};
                        adder_in_b     <= {{EXT{1'b0}}, in_b};
                        adder_start    <= 1'b1;
                        busy           <= 1'b1;
                        state          <= P1_ISSUE;
                    end
                end
                P1_ISSUE: begin
                    state <= P1_WAIT;
                end
                P1_WAIT: begin
                    if (adder_done) begin
                        r1_q           <= adder_result[N-1:0];
                        f_q            <= adder_result[AW];
                        // Correction pass: add -> R1 - M, subtract -> R1 + M.
                        adder_subtract <= ~op_q;
                        adder_in_a     <= adder_result[AW-1:0];
                        adder_in_b     <= {{EXT{1'b0}}, m_q};
                        adder_start    <= 1'b1;
                        state          <= P2_ISSUE;
                    end
                end
                P2_ISSUE: begin
                    state <= P2_WAIT;
                end
                P2_WAIT: begin
                    if (adder_done) begin
                        r2_q  <= adder_result[N-1:0];
                        g_q   <= adder_result[AW];
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    result <= sel_result;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod_addsub.sv
// tb/tb_mod_addsub.sv - directed self-checking bench for mod_addsub
module tb_mod_addsub;

    localparam int N  = 1024;
    localparam int AW = 1027;

    typedef logic [AW:0] wide_t;

    logic          clk;
    logic          resetn;
    logic          start;
    logic          subtract;
    logic [N-1:0]  in_a;
    logic [N-1:0]  in_b;
    logic [N-1:0]  in_m;
    logic [N-1:0]  result;
    logic          done;
    logic          busy;
    logic          adder_start;
    logic          adder_subtract;
    logic [AW-1:0] adder_in_a;
    logic [AW-1:0] adder_in_b;
    logic [AW:0]   adder_result;
    logic          adder_done;

    int errors = 0;
    int checks = 0;
    int astarts = 0;
    logic s1 = 1'b0;

    logic [N-1:0] mfull;
    logic [N-1:0] m13;

    mod_addsub #(.N(N), .AW(AW)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .start          (start),
        .subtract       (subtract),
        .in_a           (in_a),
        .in_b           (in_b),
        .in_m           (in_m),
        .result         (result),
        .done           (done),
        .busy           (busy),
        .adder_start    (adder_start),
        .adder_subtract (adder_subtract),
        .adder_in_a     (adder_in_a),
        .adder_in_b     (adder_in_b),
        .adder_result   (adder_result),
        .adder_done     (adder_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Adder model: done two cycles after the start cycle, borrow/carry in bit AW.
    initial begin
        adder_done   = 1'b0;
        adder_result = '0;
    end
    always @(posedge clk) begin
        s1         <= adder_start;
        adder_done <= s1;
        if (adder_start) begin
            astarts <= astarts + 1;
            if (adder_subtract)
                adder_result <= {1'b0, adder_in_a} - {1'b0, adder_in_b};
            else
                adder_result <= {1'b0, adder_in_a} + {1'b0, adder_in_b};
        end
    end

    task automatic chk(input string tag, input wide_t obs, input wide_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed(low128)=%h expected(low128)=%h", tag, obs[127:0], exp[127:0]);
        end
    endtask

    task automatic run_op(input string tag, input logic sub, input logic [N-1:0] a,
                          input logic [N-1:0] b, input logic [N-1:0] m,
                          input logic [N-1:0] exp, input int inj);
        int base;
        @(negedge clk);
        base = astarts;
        start = 1'b1; subtract = sub; in_a = a; in_b = b; in_m = m;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk($sformatf("%s/p1_start", tag), wide_t'(adder_start), wide_t'(1'b1));
                chk($sformatf("%s/p1_sub", tag), wide_t'(adder_subtract), wide_t'(sub));
                chk($sformatf("%s/p1_a", tag), wide_t'(adder_in_a), wide_t'(a));
                chk($sformatf("%s/p1_b", tag), wide_t'(adder_in_b), wide_t'(b));
            end
            if (k < 8) begin
                chk($sformatf("%s/done@%0d", tag, k), wide_t'(done), wide_t'(1'b0));
                chk($sformatf("%s/busy@%0d", tag, k), wide_t'(busy), wide_t'(1'b1));
            end else begin
                chk($sformatf("%s/done@8", tag), wide_t'(done), wide_t'(1'b1));
                chk($sformatf("%s/busy@8", tag), wide_t'(busy), wide_t'(1'b0));
                chk($sformatf("%s/result", tag), wide_t'(result), wide_t'(exp));
                chk($sformatf("%s/adder_starts", tag), wide_t'(astarts - base), wide_t'(2));
            end
            if (k == inj) begin
                start = 1'b1; subtract = ~sub; in_a = b; in_b = a; in_m = m;
            end else begin
                start = 1'b0; subtract = 1'b0; in_a = '1; in_b = '1; in_m = '0;
            end
        end
        start = 1'b0;
    endtask

    task automatic quiet(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk($sformatf("%s/q_done@%0d", tag, k), wide_t'(done), wide_t'(1'b0));
            chk($sformatf("%s/q_busy@%0d", tag, k), wide_t'(busy), wide_t'(1'b0));
            chk($sformatf("%s/q_astart@%0d", tag, k), wide_t'(adder_start), wide_t'(1'b0));
        end
    endtask

    initial begin
        mfull    = {N{1'b1}};
        m13      = N'(13);
        resetn   = 1'b0;
        start    = 1'b0;
        subtract = 1'b0;
        in_a     = '0;
        in_b     = '0;
        in_m     = '0;
        #1;
        chk("rst/result", wide_t'(result), wide_t'(0));
        chk("rst/done", wide_t'(done), wide_t'(0));
        chk("rst/busy", wide_t'(busy), wide_t'(0));
        chk("rst/adder_start", wide_t'(adder_start), wide_t'(0));
        chk("rst/adder_in_a", wide_t'(adder_in_a), wide_t'(0));
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        run_op("add_wrap", 1'b0, N'(7), N'(9), m13, N'(3), 0);
        run_op("add_nowrap", 1'b0, N'(3), N'(4), m13, N'(7), 0);
        run_op("add_max", 1'b0, N'(12), N'(12), m13, N'(11), 0);
        run_op("sub_borrow", 1'b1, N'(3), N'(9), m13, N'(7), 0);
        run_op("sub_plain", 1'b1, N'(9), N'(3), m13, N'(6), 0);
        run_op("sub_zero", 1'b1, N'(5), N'(5), m13, N'(0), 0);
        run_op("full_add", 1'b0, mfull - 1'b1, mfull - 1'b1, mfull, mfull - 2'd2, 0);
        run_op("full_sub", 1'b1, N'(0), N'(1), mfull, mfull - 1'b1, 0);

        // Second start during P1_WAIT must be dropped, not queued.
        run_op("ign_start", 1'b0, N'(7), N'(9), m13, N'(3), 2);
        quiet("ign_start", 12);

        // Back-to-back: next start issued the cycle after done.
        run_op("b2b_1", 1'b1, N'(3), N'(9), m13, N'(7), 0);
        run_op("b2b_2", 1'b0, N'(12), N'(12), m13, N'(11), 0);

        // Reset while in P2_WAIT (cycle 5 after start).
        @(negedge clk);
        start = 1'b1; subtract = 1'b0; in_a = N'(7); in_b = N'(9); in_m = m13;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid/busy", wide_t'(busy), wide_t'(1'b1));
        resetn = 1'b0;
        #1;
        chk("mid/result", wide_t'(result), wide_t'(0));
        chk("mid/done", wide_t'(done), wide_t'(0));
        chk("mid/busy0", wide_t'(busy), wide_t'(0));
        chk("mid/adder_start", wide_t'(adder_start), wide_t'(0));
        chk("mid/adder_sub", wide_t'(adder_subtract), wide_t'(0));
        chk("mid/adder_in_a", wide_t'(adder_in_a), wide_t'(0));
        chk("mid/adder_in_b", wide_t'(adder_in_b), wide_t'(0));
        @(negedge clk);
        resetn = 1'b1;
        quiet("post_rst", 8);
        chk("post_rst/result", wide_t'(result), wide_t'(0));
        run_op("after_rst", 1'b1, N'(9), N'(3), m13, N'(6), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
